maxpool2x2: RTL and testbench

- Streaming 2x2/stride-2 max-pooling stage. Sits directly downstream of the ReLU stage in the LeNet conv datapath.
- Consumes INPUT_NUM packed channels per pixel, in raster order, one pixel per valid cycle.
- Emits one pooled pixel per 2x2 window to the next conv/FC input buffer.
- A per-channel half-row line buffer holds the horizontal maxima of the even row.

---
 rtl/maxpool2x2_pkg.sv | 20 ++
 rtl/maxpool2x2_line_buf.sv | 29 ++
 rtl/maxpool2x2.sv | 121 ++++++++++++
 tb/tb_maxpool2x2.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/maxpool2x2_pkg.sv
// maxpool2x2_pkg: shared datapath widths, frame-size defaults, the per-channel
// pixel type and the signed max helper used by the pooling stage.
// Ports: none (package).
package maxpool2x2_pkg;

  // Per-channel datapath width; matches the ReLU stage output.
  localparam int WD            = 16;
  localparam int INPUT_NUM_DEF = 6;
  localparam int IMG_W_DEF     = 28;
  localparam int IMG_H_DEF     = 28;

  // One channel of a pixel, signed two's complement.
  typedef logic signed [WD-1:0] chan_t;

  // Signed per-channel maximum. On a tie either operand is the same value.
  function automatic chan_t smax(input chan_t a, input chan_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool2x2_line_buf.sv
// pool_line_buf: register-array line buffer holding one entry per 2-wide
// column pair of the even row. One synchronous write port, one async read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (combinational).
module pool_line_buf #(
  parameter int DEPTH = 14,
  parameter int DW    = 96,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read keeps the pooled result on a single registered stage.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool2x2.sv
// maxpool2x2: streaming 2x2 / stride-2 signed max pooling over INPUT_NUM packed
// channels, raster-order input, one pooled pixel per window, 1-cycle latency.
// Ports: clk, rst (sync, active-high), clr_i (frame restart), valid_i/data_i in;
//        valid_o/data_o pooled pixel out, done_o on the frame's last output.
module maxpool2x2
  import maxpool2x2_pkg::*;
#(
  parameter int INPUT_NUM = INPUT_NUM_DEF,
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [WD*INPUT_NUM-1:0] data_i,
  output logic                  valid_o,
  output logic [WD*INPUT_NUM-1:0] data_o,
  output logic                  done_o
);

  localparam int DW       = WD * INPUT_NUM;
  localparam int CW       = $clog2(IMG_W);
  localparam int RW       = $clog2(IMG_H);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic [DW-1:0] h_q, h_d;
  logic [DW-1:0] data_o_q, data_o_d;
  logic          valid_o_q, valid_o_d;
  logic          done_o_q, done_o_d;

  logic [DW-1:0] hmax;
  logic [DW-1:0] pooled;
  logic [DW-1:0] lb_rdata;
  logic          lb_we;
  logic [AW-1:0] lb_addr;
  logic          last_col;
  logic          last_row;

  // A frame restart makes the current cycle behave as pixel (0,0): any pixel
  // presented with clr_i lands in h and nothing is written or emitted.
  assign col_eff  = clr_i ? '0 : col_q;
  assign row_eff  = clr_i ? '0 : row_q;
  assign last_col = (col_eff == CW'(IMG_W - 1));
  assign last_row = (row_eff == RW'(IMG_H - 1));

  // Even row, odd column stores the horizontal max; odd row reads it back.
  // Both ports share the column-pair address and never collide in one cycle.
  assign lb_we   = valid_i & col_eff[0] & ~row_eff[0];
  assign lb_addr = AW'(col_eff >> 1);

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (hmax),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  for (genvar i = 0; i < INPUT_NUM; i++) begin : g_ch
    localparam int HI = WD * (INPUT_NUM - i) - 1;
    assign hmax[HI -: WD]   = smax(h_q[HI -: WD], data_i[HI -: WD]);
    assign pooled[HI -: WD] = smax(lb_rdata[HI -: WD], hmax[HI -: WD]);
  end

  always_comb begin
    col_d     = col_eff;
    row_d     = row_eff;
    h_d       = h_q;
    data_o_d  = data_o_q;
    valid_o_d = 1'b0;
    done_o_d  = 1'b0;
    if (valid_i) begin
      if (!col_eff[0]) begin
        h_d = data_i;
      end else if (row_eff[0]) begin
        valid_o_d = 1'b1;
        data_o_d  = pooled;
        done_o_d  = last_col & last_row;
      end
      // Raster advance; the frame wraps straight into the next one.
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      h_q       <= '0;
      data_o_q  <= '0;
      valid_o_q <= 1'b0;
      done_o_q  <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      h_q       <= h_d;
      data_o_q  <= data_o_d;
      valid_o_q <= valid_o_d;
      done_o_q  <= done_o_d;
    end
  end

  assign valid_o = valid_o_q;
  assign data_o  = data_o_q;
  assign done_o  = done_o_q;

endmodule

// File: tb/tb_maxpool2x2.sv
// tb_maxpool2x2: scoreboard bench for maxpool2x2 on a 4x4 frame, 2 channels.
// Stimulus pushes hand-computed expected pooled pixels; a negedge monitor pops
// and compares data, done flag and the exact output cycle.
module tb_maxpool2x2;
  import maxpool2x2_pkg::*;

  localparam int N  = 2;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = WD * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          done_o;

  maxpool2x2 #(
    .INPUT_NUM (N),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] dat;
    logic          done;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Hand-computed pooled values of a 4x4 ramp (ch0 = idx, ch1 = -idx).
  int exp_ramp0 [4] = '{5, 7, 13, 15};
  int exp_ramp1 [4] = '{0, -2, -8, -10};

  function automatic logic [DW-1:0] pk(input int c0, input int c1);
    return {c0[WD-1:0], c1[WD-1:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one pixel for one cycle; optionally register the output it completes.
  task automatic send(input int c0, input int c1, input bit clr,
                      input bit push, input int e0, input int e1, input bit edone);
    exp_t e;
    valid_i = 1'b1;
    clr_i   = clr;
    data_i  = pk(c0, c1);
    if (push) begin
      e.dat  = pk(e0, e1);
      e.done = edone;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    clr_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ramp pixels first..last of a 4x4 frame, gap idle cycles after each.
  task automatic ramp(input int off, input int first, input int last, input int gap);
    int k;
    for (int i = first; i <= last; i++) begin
      k = (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : (i == 15) ? 3 : -1;
      if (k >= 0)
        send(off + i, -i, 1'b0, 1'b1, off + exp_ramp0[k], exp_ramp1[k], k == 3);
      else
        send(off + i, -i, 1'b0, 1'b0, 0, 0, 1'b0);
      idle(gap);
    end
  endtask

  // Monitor: every valid_o must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(data_o), 64'hdead);
      end else begin
        e = sb.pop_front();
        check("data_o", 64'(data_o), 64'(e.dat));
        check("done_o", 64'(done_o), 64'(e.done));
        check("out_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (done_o) begin
      check("done_without_valid", 64'(done_o), 64'd0);
    end
  end

  initial begin
    rst     = 1'b1;
    clr_i   = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    idle(2);
    check("reset_valid_o", 64'(valid_o), 64'd0);
    check("reset_done_o", 64'(done_o), 64'd0);
    check("reset_data_o", 64'(data_o), 64'd0);
    rst = 1'b0;
    idle(2);

    // Plain ramp.
    ramp(0, 0, 15, 0);
    idle(3);

    // Signed per-channel window; remaining pixels are zero.
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:  send(-3, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        1:  send(-1, 9, 1'b0, 1'b0, 0, 0, 1'b0);
        4:  send(-7, 4, 1'b0, 1'b0, 0, 0, 1'b0);
        5:  send(-2, 9, 1'b0, 1'b1, -1, 9, 1'b0);
        7:  send(0, 0, 1'b0, 1'b1, 0, 0, 1'b0);
        13: send(0, 0, 1'b0, 1'b1, 0, 0, 1'b0);
        15: send(0, 0, 1'b0, 1'b1, 0, 0, 1'b1);
        default: send(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
      endcase
    end
    idle(3);

    // Bubbles: 3 idle cycles after every pixel.
    ramp(0, 0, 15, 3);
    idle(3);

    // Back-to-back frames with no gap.
    ramp(0, 0, 15, 0);
    ramp(100, 0, 15, 0);
    idle(3);

    // Restart at row 1, col 2 with pixel 50 becoming (0,0) of a new frame.
    ramp(0, 0, 5, 0);
    send(50, -50, 1'b1, 1'b0, 0, 0, 1'b0);
    send(1, -1, 1'b0, 1'b0, 0, 0, 1'b0);
    send(2, -2, 1'b0, 1'b0, 0, 0, 1'b0);
    send(3, -3, 1'b0, 1'b0, 0, 0, 1'b0);
    send(4, -4, 1'b0, 1'b0, 0, 0, 1'b0);
    send(5, -5, 1'b0, 1'b1, 50, -1, 1'b0);
    ramp(0, 6, 15, 0);
    idle(3);

    // Reset during row 3, then a full ramp.
    ramp(0, 0, 12, 0);
    rst     = 1'b1;
    valid_i = 1'b1;
    data_i  = pk(77, 77);
    @(posedge clk);
    #1;
    check("midrst_valid_o", 64'(valid_o), 64'd0);
    check("midrst_done_o", 64'(done_o), 64'd0);
    check("midrst_data_o", 64'(data_o), 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    idle(1);
    ramp(0, 0, 15, 0);
    idle(4);

    check("outputs_outstanding", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
